// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Bundles the control inputs and display outputs of the 8-digit scan
//   controller so the controller and its driver share one port.
//
//   en         1 = scanning, 0 = display dark and scan parked at digit 0
//   value[31:0] value to display (hex), captured on upd
//   upd        1-cycle strobe: capture value as the pending frame value
//   lzb        1 = leading-zero blanking per 4-digit group (sampled live)
//   an[7:0]    digit selects, active-high
//   seg_lo[6:0] segments for digits 0-3 (bit0=a .. bit6=g)
//   seg_hi[6:0] segments for digits 4-7
//   frame_done 1-cycle pulse when the scan wraps from digit 3 to digit 0
//
//   master: the side that drives en/value/upd/lzb
//   slave : the scan controller itself
interface seg_scan_ctrl_if;
    logic        en;
    logic [31:0] value;
    logic        upd;
    logic        lzb;
    logic [7:0]  an;
    logic [6:0]  seg_lo;
    logic [6:0]  seg_hi;
    logic        frame_done;

    modport master (
        output en, value, upd, lzb,
        input  an, seg_lo, seg_hi, frame_done
    );

    modport slave (
        input  en, value, upd, lzb,
        output an, seg_lo, seg_hi, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit, two-bus 7-segment
//   display. Digits 0-3 show shown[15:0] on seg_lo, digits 4-7 show
//   shown[31:16] on seg_hi; digit i and digit 4+i are lit together.
//   Each digit is lit for TICK_DIV cycles, followed by GUARD_CYC dark
//   cycles (skipped when GUARD_CYC = 0). New values are held as pending
//   and only become visible at a frame boundary, so a scanned frame never
//   mixes two values.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous reset, active-low
//     bus  seg_scan_ctrl_if.slave (en, value, upd, lzb in;
//          an, seg_lo, seg_hi, frame_done out, all registered)
//
//   Parameters:
//     TICK_DIV   cycles each digit is lit, 2 .. 2^20
//     GUARD_CYC  dark cycles between digits, 0 disables the guard phase
module seg_scan_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GUARD_CYC = 1000
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned LEN_A   = (TICK_DIV > 2) ? TICK_DIV : 2;
    localparam int unsigned MAX_LEN = (GUARD_CYC > LEN_A) ? GUARD_CYC : LEN_A;
    localparam int unsigned CW      = $clog2(MAX_LEN);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? (GUARD_CYC - 1) : 0);
    localparam bit            HAS_GUARD  = (GUARD_CYC > 0);

    typedef enum logic {
        ST_SHOW,
        ST_GUARD
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   shown;
    logic [31:0]   pending;
    logic          pend_flag;

    logic          show_end;
    logic          guard_end;
    logic          frame_evt;
    logic          blank_lo;
    logic          blank_hi;
    logic [7:0]    an_nx;
    logic [6:0]    seg_lo_nx;
    logic [6:0]    seg_hi_nx;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nib_at(input logic [15:0] h, input logic [1:0] k);
        logic [3:0] n;
        case (k)
            2'd0:    n = h[3:0];
            2'd1:    n = h[7:4];
            2'd2:    n = h[11:8];
            default: n = h[15:12];
        endcase
        return n;
    endfunction

    // Digit k of a group is a leading zero when it and every higher
    // nibble of the group are zero; digit 0 always stays lit.
    function automatic logic lead_zero(input logic [15:0] h, input logic [1:0] k);
        logic z;
        case (k)
            2'd0:    z = 1'b0;
            2'd1:    z = (h[15:4] == 12'd0);
            2'd2:    z = (h[15:8] == 8'd0);
            default: z = (h[15:12] == 4'd0);
        endcase
        return z;
    endfunction

    always_comb begin
        show_end  = (state == ST_SHOW)  && (cnt == SHOW_LAST);
        guard_end = (state == ST_GUARD) && (cnt == GUARD_LAST);
        // Digit 3 is left from GUARD normally, or straight from SHOW when
        // the guard phase is configured away.
        frame_evt = bus.en && (idx == 2'd3) &&
                    (guard_end || (show_end && !HAS_GUARD));
    end

    always_comb begin
        blank_lo  = bus.lzb && lead_zero(shown[15:0], idx);
        blank_hi  = bus.lzb && lead_zero(shown[31:16], idx);
        seg_lo_nx = blank_lo ? 7'd0 : hex7(nib_at(shown[15:0], idx));
        seg_hi_nx = blank_hi ? 7'd0 : hex7(nib_at(shown[31:16], idx));
        an_nx     = '0;
        if (state == ST_SHOW) begin
            an_nx[{1'b0, idx}] = !blank_lo;
            an_nx[{1'b1, idx}] = !blank_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_SHOW;
            idx            <= '0;
            cnt            <= '0;
            shown          <= '0;
            pending        <= '0;
            pend_flag      <= 1'b0;
            bus.an         <= '0;
            bus.seg_lo     <= '0;
            bus.seg_hi     <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            // The old pending value is committed before a same-cycle upd
            // replaces it, so that upd waits for the following boundary.
            if (frame_evt && pend_flag) begin
                shown <= pending;
            end
            if (bus.upd) begin
                pending   <= bus.value;
                pend_flag <= 1'b1;
            end else if (frame_evt) begin
                pend_flag <= 1'b0;
            end

            if (!bus.en) begin
                state          <= ST_SHOW;
                idx            <= '0;
                cnt            <= '0;
                bus.an         <= '0;
                bus.frame_done <= 1'b0;
            end else begin
                bus.frame_done <= frame_evt;
                bus.an         <= an_nx;
                // Segment buses keep the last digit's pattern while dark.
                if (state == ST_SHOW) begin
                    bus.seg_lo <= seg_lo_nx;
                    bus.seg_hi <= seg_hi_nx;
                end

                case (state)
                    ST_SHOW: begin
                        if (show_end) begin
                            cnt <= '0;
                            if (HAS_GUARD) begin
                                state <= ST_GUARD;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (guard_end) begin
                            cnt   <= '0;
                            state <= ST_SHOW;
                            idx   <= idx + 2'd1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= ST_SHOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with TICK_DIV=4, GUARD_CYC=2, plus
//   a second instance with GUARD_CYC=0. The reference model tracks the scan
//   as a position inside a 24-cycle frame and derives the lit digit and
//   phase arithmetically.
module tb_seg_scan_ctrl;

    localparam int unsigned T = 4;
    localparam int unsigned G = 2;
    localparam int unsigned D = T + G;
    localparam int unsigned P = 4 * D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_ctrl_if ifc ();
    seg_scan_ctrl_if ifc0 ();

    assign ifc0.en    = ifc.en;
    assign ifc0.value = ifc.value;
    assign ifc0.upd   = ifc.upd;
    assign ifc0.lzb   = ifc.lzb;

    seg_scan_ctrl #(.TICK_DIV(T), .GUARD_CYC(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    seg_scan_ctrl #(.TICK_DIV(T), .GUARD_CYC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0.slave)
    );

    int errors = 0;
    int checks = 0;

    int unsigned m_q;
    logic [31:0] m_shown;
    logic [31:0] m_pend;
    logic        m_pflag;
    logic [7:0]  exp_an;
    logic [6:0]  exp_lo;
    logic [6:0]  exp_hi;
    logic        exp_fd;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Advance one clock: predict outputs from the model state before the
    // edge, then move the model forward; returns 1 ns after the edge.
    task automatic tick();
        logic [15:0] half;
        logic [6:0]  seg;
        logic        blank;
        int unsigned d;
        @(posedge clk);
        if (!rst) begin
            m_q = 0; m_shown = '0; m_pend = '0; m_pflag = 1'b0;
            exp_an = '0; exp_lo = '0; exp_hi = '0; exp_fd = 1'b0;
        end else begin
            if (ifc.en) begin
                d      = m_q / D;
                exp_fd = (m_q == P - 1);
                exp_an = '0;
                if ((m_q % D) < T) begin
                    for (int g = 0; g < 2; g++) begin
                        half  = (g == 1) ? m_shown[31:16] : m_shown[15:0];
                        blank = ifc.lzb && (d > 0) && ((half >> (4 * d)) == 16'd0);
                        seg   = blank ? 7'd0 : seg_of(4'(half >> (4 * d)));
                        if (!blank) exp_an[4 * g + int'(d)] = 1'b1;
                        if (g == 0) exp_lo = seg; else exp_hi = seg;
                    end
                end
                if (m_q == P - 1 && m_pflag) begin
                    m_shown = m_pend;
                    m_pflag = 1'b0;
                end
                m_q = (m_q + 1) % P;
            end else begin
                exp_an = '0;
                exp_fd = 1'b0;
                m_q    = 0;
            end
            if (ifc.upd) begin
                m_pend  = ifc.value;
                m_pflag = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ifc.en = 1'b0; ifc.upd = 1'b0; ifc.value = '0; ifc.lzb = 1'b0;
        repeat (3) tick();
        checks++; if (ifc.an !== 8'h00) begin errors++; $display("FAIL reset_an got=%h exp=00", ifc.an); end
        checks++; if (ifc.seg_lo !== 7'h00) begin errors++; $display("FAIL reset_seg_lo got=%h exp=00", ifc.seg_lo); end
        checks++; if (ifc.seg_hi !== 7'h00) begin errors++; $display("FAIL reset_seg_hi got=%h exp=00", ifc.seg_hi); end
        checks++; if (ifc.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", ifc.frame_done); end
    endtask

    task automatic test_first_value();
        int hits;
        int pulses;
        rst = 1'b1; ifc.en = 1'b1; ifc.upd = 1'b1; ifc.value = 32'h8765_4321;
        tick();
        ifc.upd = 1'b0;
        checks++;
        if ({ifc.an, ifc.seg_lo, ifc.seg_hi} !== {8'h11, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL first_digit got an=%h lo=%h hi=%h exp an=11 lo=3f hi=3f", ifc.an, ifc.seg_lo, ifc.seg_hi);
        end
        hits = 0; pulses = 0;
        for (int n = 1; n < 2 * P; n++) begin
            tick();
            if (ifc.an === 8'h11 && ifc.seg_lo === 7'h06 && ifc.seg_hi === 7'h6D) hits++;
            if (ifc.frame_done === 1'b1) pulses++;
            checks++;
            if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                errors++;
                $display("FAIL model_first t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                         $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
            end
        end
        checks++; if (hits != 4) begin errors++; $display("FAIL digit0_new_value cycles got=%0d exp=4", hits); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL frame_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_tear_free();
        logic [6:0] want;
        ifc.upd = 1'b1; ifc.value = 32'h1111_1111;
        tick();
        ifc.upd = 1'b0;
        for (int n = 0; n < P + 2 && m_q != 0; n++) tick();
        for (int n = 0; n < P && m_q != 2 * D + 1; n++) tick();
        ifc.upd = 1'b1; ifc.value = 32'h2222_2222;
        tick();
        ifc.upd = 1'b0;
        for (int n = 0; n < P + 2 && m_q != 0; n++) begin
            tick();
            if (ifc.an !== 8'h00 && ifc.frame_done !== 1'b1) begin
                checks++;
                if (ifc.seg_lo !== 7'h06) begin errors++; $display("FAIL tear_old_frame an=%h got lo=%h exp=06", ifc.an, ifc.seg_lo); end
            end
        end
        // Frames after the boundary: 2222, then 4444 applied at a boundary
        // where 3333 arrives in the same cycle, then 3333.
        for (int f = 0; f < 3; f++) begin
            want = (f == 0) ? 7'h5B : ((f == 1) ? 7'h66 : 7'h4F);
            for (int n = 0; n < P; n++) begin
                if (f == 0 && n == P - 3) begin ifc.upd = 1'b1; ifc.value = 32'h4444_4444; end
                if (f == 0 && n == P - 1) begin ifc.upd = 1'b1; ifc.value = 32'h3333_3333; end
                tick();
                ifc.upd = 1'b0;
                if (ifc.an !== 8'h00) begin
                    checks++;
                    if (ifc.seg_lo !== want || ifc.seg_hi !== want) begin
                        errors++;
                        $display("FAIL tear_frame%0d got lo=%h hi=%h exp=%h", f, ifc.seg_lo, ifc.seg_hi, want);
                    end
                end
                checks++;
                if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                    errors++;
                    $display("FAIL model_tear t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                             $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
                end
            end
        end
    endtask

    task automatic test_blank();
        int n11, n02, other;
        logic [7:0] seen;
        ifc.lzb = 1'b1; ifc.upd = 1'b1; ifc.value = 32'h0000_0012;
        tick();
        ifc.upd = 1'b0;
        for (int n = 0; n < P + 2 && m_q != 0; n++) tick();
        n11 = 0; n02 = 0; other = 0;
        for (int n = 0; n < P; n++) begin
            tick();
            if (ifc.an === 8'h11) begin
                n11++;
                checks++;
                if (ifc.seg_lo !== 7'h5B || ifc.seg_hi !== 7'h3F) begin errors++; $display("FAIL blank_d0 got lo=%h hi=%h exp lo=5b hi=3f", ifc.seg_lo, ifc.seg_hi); end
            end else if (ifc.an === 8'h02) begin
                n02++;
                checks++;
                if (ifc.seg_lo !== 7'h06) begin errors++; $display("FAIL blank_d1 got lo=%h exp=06", ifc.seg_lo); end
            end else if (ifc.an !== 8'h00) other++;
            checks++;
            if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                errors++;
                $display("FAIL model_blank t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                         $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
            end
        end
        checks++;
        if (n11 != 4 || n02 != 4 || other != 0) begin
            errors++;
            $display("FAIL blank_pattern got n11=%0d n02=%0d other=%0d exp 4 4 0", n11, n02, other);
        end
        ifc.lzb = 1'b0;
        seen = '0;
        for (int n = 0; n < P; n++) begin
            tick();
            seen = seen | ifc.an;
        end
        checks++; if (seen !== 8'hFF) begin errors++; $display("FAIL no_blank_all_lit got=%h exp=ff", seen); end
    endtask

    task automatic test_en_drop();
        for (int n = 0; n < P && m_q != 2 * D + 1; n++) tick();
        ifc.en = 1'b0; ifc.upd = 1'b1; ifc.value = 32'h5555_5555;
        tick();
        ifc.upd = 1'b0;
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (ifc.an !== 8'h00 || ifc.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL en_low_dark got an=%h fd=%b exp an=00 fd=0", ifc.an, ifc.frame_done);
            end
            tick();
        end
        ifc.en = 1'b1;
        for (int n = 0; n < 2 * P + 1; n++) begin
            tick();
            if (n < 5) begin
                checks++;
                if (ifc.an !== ((n < 4) ? 8'h11 : 8'h00)) begin
                    errors++;
                    $display("FAIL en_restart cyc=%0d got an=%h exp=%h", n, ifc.an, (n < 4) ? 8'h11 : 8'h00);
                end
            end
            checks++;
            if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                errors++;
                $display("FAIL model_en t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                         $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        ifc.upd = 1'b1; ifc.value = 32'h9999_9999;
        tick();
        ifc.upd = 1'b0;
        for (int n = 0; n < P && m_q != 4; n++) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got an=%h lo=%h hi=%h fd=%b exp all 0", ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done);
        end
        tick();
        rst = 1'b1;
        for (int n = 0; n < 2 * P; n++) begin
            tick();
            if (ifc.an !== 8'h00) begin
                checks++;
                if (ifc.seg_lo !== 7'h3F || ifc.seg_hi !== 7'h3F) begin
                    errors++;
                    $display("FAIL post_reset_zero got lo=%h hi=%h exp 3f", ifc.seg_lo, ifc.seg_hi);
                end
            end
            if (n == 0) begin
                checks++;
                if (ifc.an !== 8'h11) begin errors++; $display("FAIL post_reset_digit0 got an=%h exp=11", ifc.an); end
            end
            checks++;
            if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                errors++;
                $display("FAIL model_rst t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                         $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int n = 0; n < 500; n++) begin
            ifc.upd = ($urandom_range(0, 9) == 0);
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 7));
            ifc.value = v;
            if ($urandom_range(0, 15) == 0) ifc.lzb = ~ifc.lzb;
            ifc.en = ($urandom_range(0, 39) != 0);
            tick();
            checks++;
            if ({ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done} !== {exp_an, exp_lo, exp_hi, exp_fd}) begin
                errors++;
                $display("FAIL model_random t=%0t got an=%h lo=%h hi=%h fd=%b exp an=%h lo=%h hi=%h fd=%b",
                         $time, ifc.an, ifc.seg_lo, ifc.seg_hi, ifc.frame_done, exp_an, exp_lo, exp_hi, exp_fd);
            end
        end
        ifc.upd = 1'b0; ifc.en = 1'b1;
    endtask

    task automatic test_no_guard();
        ifc.lzb = 1'b0; ifc.upd = 1'b0; ifc.en = 1'b0;
        tick();
        ifc.en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (ifc0.frame_done !== ((k % 16) == 0)) begin
                errors++;
                $display("FAIL noguard_fd cyc=%0d got=%b exp=%b", k, ifc0.frame_done, (k % 16) == 0);
            end
            checks++;
            if (ifc0.an === 8'h00) begin
                errors++;
                $display("FAIL noguard_dark cyc=%0d got an=%h exp nonzero", k, ifc0.an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_value();
        test_tear_free();
        test_blank();
        test_en_drop();
        test_async_reset();
        test_random();
        test_no_guard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
